// File: rtl/mem_port_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : mem_port_arbiter
//  Description : Shares one single-ported memory between the fetch port (I,
//                read-only) and the memory-stage port (D, load/store).
//                D has priority, except that a fetch denied for STARVE_MAX
//                consecutive cycles wins the next arbitration.
//                Every read grant enters a RD_LAT-deep {valid, owner} tag
//                pipeline. The head of that pipeline sends mem_rdata back to
//                the port that issued the read.
//                Optional build macro MEM_ARB_PERF_EN adds two counters:
//                arbitration conflicts and starvation wins.
//  Revision    : 1.0 - initial release
// ============================================================================
module mem_port_arbiter #(
   parameter int RD_LAT     = 2,
   parameter int STARVE_MAX = 3
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        clk_en,
   input  logic        i_req,
   input  logic [31:0] i_addr,
   input  logic        i_flush,
   input  logic        d_re,
   input  logic [3:0]  d_we,
   input  logic [31:0] d_addr,
   input  logic [31:0] d_wdata,
   input  logic [31:0] mem_rdata,
   output logic [31:0] mem_addr,
   output logic        mem_re,
   output logic [3:0]  mem_we,
   output logic [31:0] mem_wdata,
   output logic        i_gnt,
   output logic        d_gnt,
   output logic        i_stall,
   output logic        d_stall,
   output logic        i_rvalid,
   output logic [31:0] i_rdata,
   output logic        d_rvalid,
   output logic [31:0] d_rdata
`ifdef MEM_ARB_PERF_EN
   ,
   output logic [31:0] perf_conflicts,
   output logic [31:0] perf_starve_wins
`endif
);

   localparam int         c_CNT_W      = 4;
   localparam logic [3:0] c_STARVE_MAX = c_CNT_W'(STARVE_MAX);

   logic               w_d_wr;
   logic               w_d_req;
   logic               w_active;
   logic               w_i_ok;
   logic               w_starve;
   logic               w_i_gnt;
   logic               w_d_gnt;
   logic               w_head_i;
   logic               w_head_d;
   logic [c_CNT_W-1:0] r_starve_cnt;
   logic [RD_LAT-1:0]  r_vld;
   logic [RD_LAT-1:0]  r_own;   // 1 = owned by D

   // A nonzero byte mask always makes the access a write.
   // While reset is asserted no request is considered at all, so every
   // output reads 0.
   assign w_d_wr   = |d_we;
   assign w_d_req  = d_re | w_d_wr;
   assign w_active = clk_en & rst_n;
   assign w_i_ok   = i_req & ~i_flush;
   assign w_starve = w_i_ok & (r_starve_cnt == c_STARVE_MAX);

   // Same-cycle arbitration: a starved fetch first, then D, then a normal fetch.
   always_comb begin
      w_i_gnt = 1'b0;
      w_d_gnt = 1'b0;
      if (w_active) begin
         if (w_starve)
            w_i_gnt = 1'b1;
         else if (w_d_req)
            w_d_gnt = 1'b1;
         else if (w_i_ok)
            w_i_gnt = 1'b1;
      end
   end

   // Drive the memory macro from the granted request; idle drives all zeros.
   always_comb begin
      mem_addr  = '0;
      mem_re    = 1'b0;
      mem_we    = '0;
      mem_wdata = '0;
      if (w_i_gnt) begin
         mem_addr = i_addr;
         mem_re   = 1'b1;
      end else if (w_d_gnt) begin
         mem_addr = d_addr;
         if (w_d_wr) begin
            mem_we    = d_we;
            mem_wdata = d_wdata;
         end else begin
            mem_re = 1'b1;
         end
      end
   end

   // Grants, stalls and response routing from the pipeline head.
   // A flush in an enabled cycle also suppresses a fetch response that is
   // landing in that same cycle.
   always_comb begin
      w_head_i = r_vld[RD_LAT-1] & ~r_own[RD_LAT-1];
      w_head_d = r_vld[RD_LAT-1] &  r_own[RD_LAT-1];
      i_gnt    = w_i_gnt;
      d_gnt    = w_d_gnt;
      i_stall  = rst_n & i_req   & ~w_i_gnt;
      d_stall  = rst_n & w_d_req & ~w_d_gnt;
      i_rvalid = w_head_i & ~(clk_en & i_flush);
      d_rvalid = w_head_d;
      i_rdata  = i_rvalid ? mem_rdata : '0;
      d_rdata  = d_rvalid ? mem_rdata : '0;
   end

   // Tag pipeline: stage 0 captures this cycle's read grant. A flush drops
   // every fetch-owned entry as it shifts along.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_vld <= '0;
         r_own <= '0;
      end else if (clk_en) begin
         r_vld[0] <= mem_re;
         r_own[0] <= w_d_gnt;
         for (int k = 1; k < RD_LAT; k++) begin
            r_vld[k] <= r_vld[k-1] & ~(i_flush & ~r_own[k-1]);
            r_own[k] <= r_own[k-1];
         end
      end
   end

   // Count consecutive denied fetch cycles, saturating at the starvation limit.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_starve_cnt <= '0;
      end else if (clk_en) begin
         if (w_i_gnt || !i_req || i_flush)
            r_starve_cnt <= '0;
         else if (r_starve_cnt != c_STARVE_MAX)
            r_starve_cnt <= r_starve_cnt + 1'b1;
      end
   end

`ifdef MEM_ARB_PERF_EN
   // Performance counters. Both wrap at 2^32.
   // A starvation win is counted only when D was actually passed over.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         perf_conflicts   <= '0;
         perf_starve_wins <= '0;
      end else if (clk_en) begin
         if (i_req && w_d_req && !i_flush)
            perf_conflicts <= perf_conflicts + 32'd1;
         if (w_starve && w_d_req)
            perf_starve_wins <= perf_starve_wins + 32'd1;
      end
   end
`endif

endmodule
`default_nettype wire

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares the single-ported data/instruction memory between the fetch stage (read-only, port I) and the memory stage (load/store, port D).
- Issues at most one access per enabled cycle, tracks in-flight reads through a fixed-latency tag pipeline, and routes each read response back to its owner.
- Generates per-port stall signals and prevents fetch starvation.
- Sits between the fetch/memory pipeline registers and the memory macro.

Parameters:
RD_LAT, 2, memory read latency in enabled cycles (1..4) from mem_re to mem_rdata valid
STARVE_MAX, 3, consecutive denied fetch cycles after which fetch wins arbitration (1..15)

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
clk_en  in  1  global clock enable; all state advances only when high
i_req  in  1  fetch read request
i_addr  in  32  fetch address
i_flush  in  1  fetch redirect; kill in-flight and current fetch
d_re  in  1  memory-stage load request
d_we  in  4  memory-stage byte write enables
d_addr  in  32  memory-stage address
d_wdata  in  32  store data
mem_rdata  in  32  memory read data
mem_addr  out  32  memory address
mem_re  out  1  memory read strobe
mem_we  out  4  memory byte write strobes
mem_wdata  out  32  memory write data
i_gnt  out  1  fetch request accepted this cycle
d_gnt  out  1  memory-stage request accepted this cycle
i_stall  out  1  i_req && !i_gnt
d_stall  out  1  d_req && !d_gnt
i_rvalid  out  1  fetch read data valid
i_rdata  out  32  fetch read data
d_rvalid  out  1  load data valid
d_rdata  out  32  load data

Behaviour:
- d_req = d_re || (d_we != 0). If d_we != 0, the access is a write and d_re is ignored.
- Arbitration is combinational, same cycle as the request.
  - Default priority: D over I.
  - If starve_cnt == STARVE_MAX and i_req is high and i_flush is low, I wins over D.
- i_flush high: i_gnt = 0 regardless of i_req. i_stall is still i_req && !i_gnt.
- clk_en low:
  - i_gnt = d_gnt = 0, mem_re = 0, mem_we = 0.
  - Stalls follow their formulas.
  - No state changes.
- Granted read: mem_re = 1, mem_addr = granted address, mem_we = 0.
- Granted write: mem_we = d_we, mem_wdata = d_wdata, mem_addr = d_addr, mem_re = 0. Writes produce no response.
- No grant: mem_addr = 0, mem_re = 0, mem_we = 0, mem_wdata = 0.
- Tag pipeline: RD_LAT stages of {valid, owner}.
  - Stage 0 loads {mem_re, owner_is_D} on each enabled cycle; all stages shift when clk_en is high.
  - The head (last stage) drives i_rvalid = valid && !owner and d_rvalid = valid && owner.
  - Response lands exactly RD_LAT enabled cycles after the grant cycle.
- rdata outputs are mem_rdata when the corresponding rvalid is high, else 0.
- i_flush (enabled cycle): clears valid on every in-flight I-owned stage, including the head entry's effect on i_rvalid that same cycle (i_rvalid forced 0). D entries are unaffected.
- starve_cnt, updated on enabled cycles:
  - Resets to 0 on i_gnt, on !i_req, or on i_flush.
  - Otherwise increments, saturating at STARVE_MAX.
- Back-to-back grants each cycle are legal; the pipeline sustains one read per cycle.
- Reset (asynchronous, any time, including with reads in flight):
  - All tag stages invalid and starve_cnt = 0.
  - All outputs 0, including the rvalids.
  - Responses for pre-reset reads are never delivered.

Optional Feature:
MEM_ARB_PERF_EN:
- Defined: adds outputs perf_conflicts[31:0] and perf_starve_wins[31:0].
  - perf_conflicts counts enabled cycles with i_req && d_req && !i_flush.
  - perf_starve_wins counts cycles where I won via starvation.
  - Both wrap at 2^32 and reset to 0.
- Undefined: the ports and counters do not exist, and arbitration behaviour is identical.

Test Plan:
1. RD_LAT=2. I read 0x100 at cycle 0, D idle -> i_gnt=1, mem_re=1, mem_addr=0x100 at cycle 0; i_rvalid=1 with i_rdata=mem_rdata at cycle 2; d_rvalid=0 throughout.
2. i_req and d_re both held high (addrs 0x100/0x200) -> D granted in cycles 0-2; I granted in cycle 3 (starve_cnt=3); D granted again in cycle 4. Responses return in grant order with correct owners. Under the macro, perf_starve_wins=1.
3. Store d_we=4'b0011, d_wdata=0xDEADBEEF, addr 0x40 -> mem_we=0011, mem_wdata=0xDEADBEEF at the grant cycle; no rvalid 2 cycles later. Store with d_re=1 also -> still a write, mem_re=0.
4. I read granted at cycle 0, D load granted at cycle 1, i_flush at cycle 1 -> i_rvalid stays 0 at cycle 2; d_rvalid=1 at cycle 3. A flush-cycle i_req gets i_gnt=0, i_stall=1.
5. clk_en low for 3 cycles between a grant and its response -> response arrives after 2 enabled cycles (5 wall cycles); no grants during the low cycles; stalls asserted for active requests.
6. Assert rst_n=0 mid-flight with 2 reads outstanding -> all outputs immediately 0. After release, no stale rvalid, and starve_cnt restarts from 0.
